// File: rtl/gene_line_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gene_pkg
// Description : Shared constants, base codes and FSM state type for the
//               gene line sequencer and its compressor.
// Revision    : 1.0 - initial release
// ============================================================================
package gene_pkg;

    localparam int LINE_CHARS = 100;
    localparam int LINE_BITS  = 800;
    localparam int PACK_BITS  = 200;

    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_C  = 8'h43;
    localparam logic [7:0] ASCII_G  = 8'h47;
    localparam logic [7:0] ASCII_T  = 8'h54;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    localparam logic [1:0] CODE_A = 2'b00;
    localparam logic [1:0] CODE_C = 2'b01;
    localparam logic [1:0] CODE_G = 2'b10;
    localparam logic [1:0] CODE_T = 2'b11;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        COMP = 2'd1,
        EMIT = 2'd2
    } state_t;

    // The line buffer only ever holds A/C/G/T; anything else maps to A.
    function automatic logic [1:0] base_code(input logic [7:0] ch);
        case (ch)
            ASCII_C: base_code = CODE_C;
            ASCII_G: base_code = CODE_G;
            ASCII_T: base_code = CODE_T;
            default: base_code = CODE_A;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/gene_line_compress.sv
`default_nettype none
// ============================================================================
// Module      : gene_line_compress
// Description : Combinational 800->200 bit packer. Char slot g (MSB-first)
//               becomes the 2-bit code at packed bits [199-2g -: 2].
// Ports       : i_line   - 100 ASCII characters, slot 0 in [799:792]
//               o_packed - 100 two-bit base codes, base 0 in [199:198]
// Revision    : 1.0 - initial release
// ============================================================================
module gene_line_compress
    import gene_pkg::*;
(
    input  logic [LINE_BITS-1:0] i_line,
    output logic [PACK_BITS-1:0] o_packed
);

    for (genvar g = 0; g < LINE_CHARS; g++) begin : g_slot
        assign o_packed[PACK_BITS-1-2*g -: 2] = base_code(i_line[LINE_BITS-1-8*g -: 8]);
    end

endmodule
`default_nettype wire

// File: rtl/gene_line_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gene_line_sequencer
// Description : Collects ASCII nucleotides into a 100-character line buffer,
//               closes the line on full / newline / flush, packs it through
//               gene_line_compress and offers the result on a valid/ready port.
// Ports       : clk, rst_n          - clock, async active-low reset
//               in_char/in_valid/in_ready - character input stream
//               flush              - close a partial line
//               out_line/out_len/out_err/out_valid/out_ready - packed line
//               line_count         - lines emitted, wraps silently
// Revision    : 1.0 - initial release
// ============================================================================
module gene_line_sequencer #(
    parameter int LINE_CHARS = 100,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              in_char,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [2*LINE_CHARS-1:0] out_line,
    output logic [6:0]              out_len,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CNT_W-1:0]        line_count
);

    import gene_pkg::*;

    localparam logic [8*LINE_CHARS-1:0] c_buf_init = {LINE_CHARS{ASCII_A}};
    localparam logic [6:0]              c_line_len = 7'(LINE_CHARS);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [8*LINE_CHARS-1:0] r_buf;
    logic [6:0]              r_cnt;
    logic                    r_err;
    logic [2*LINE_CHARS-1:0] r_out_line;
    logic [6:0]              r_out_len;
    logic                    r_out_err;
    logic [CNT_W-1:0]        r_line_count;

    logic [2*LINE_CHARS-1:0] w_packed;
    logic                    w_accept;
    logic                    w_is_lf;
    logic                    w_is_cr;
    logic                    w_is_acgt;
    logic                    w_take_base;
    logic [6:0]              w_cnt_inc;
    logic                    w_close;
    logic                    w_handshake;
    logic [7:0]              w_store_char;
    logic [9:0]              w_slot_lsb;

    gene_line_compress u_compress (
        .i_line   (r_buf),
        .o_packed (w_packed)
    );

    assign w_accept     = in_valid && (r_state == FILL);
    assign w_is_lf      = (in_char == ASCII_LF);
    assign w_is_cr      = (in_char == ASCII_CR);
    assign w_is_acgt    = (in_char == ASCII_A) || (in_char == ASCII_C) ||
                          (in_char == ASCII_G) || (in_char == ASCII_T);
    assign w_take_base  = w_accept && !w_is_lf && !w_is_cr;
    assign w_cnt_inc    = r_cnt + 7'(w_take_base);
    assign w_store_char = w_is_acgt ? in_char : ASCII_A;
    // Slot 0 sits at the top of the buffer; only used while r_cnt < LINE_CHARS.
    assign w_slot_lsb   = 10'((LINE_CHARS - 1 - int'(r_cnt)) * 8);
    assign w_handshake  = (r_state == EMIT) && out_ready;

    // Flush is judged against the count including a base taken this cycle.
    assign w_close = (r_state == FILL) &&
                     ((w_take_base && (w_cnt_inc == c_line_len)) ||
                      (w_accept && w_is_lf && (r_cnt != 7'd0)) ||
                      (flush && (w_cnt_inc != 7'd0)));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FILL:    if (w_close) w_next_state = COMP;
            COMP:    w_next_state = EMIT;
            EMIT:    if (out_ready) w_next_state = FILL;
            default: w_next_state = FILL;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready  = (r_state == FILL);
        out_valid = (r_state == EMIT);
    end

    // Line buffer, counters and output word registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf        <= c_buf_init;
            r_cnt        <= 7'd0;
            r_err        <= 1'b0;
            r_out_line   <= '0;
            r_out_len    <= 7'd0;
            r_out_err    <= 1'b0;
            r_line_count <= '0;
        end else begin
            if (w_take_base) begin
                r_buf[w_slot_lsb +: 8] <= w_store_char;
                r_cnt                  <= w_cnt_inc;
                if (!w_is_acgt) begin
                    r_err <= 1'b1;
                end
            end
            if (r_state == COMP) begin
                r_out_line <= w_packed;
                r_out_len  <= r_cnt;
                r_out_err  <= r_err;
            end
            if (w_handshake) begin
                r_line_count <= r_line_count + CNT_W'(1);
                r_buf        <= c_buf_init;
                r_cnt        <= 7'd0;
                r_err        <= 1'b0;
            end
        end
    end

    assign out_line   = r_out_line;
    assign out_len    = r_out_len;
    assign out_err    = r_out_err;
    assign line_count = r_line_count;

endmodule
`default_nettype wire

// File: tb/tb_gene_line_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gene_line_sequencer
// Description : Randomized self-checking bench for gene_line_sequencer with a
//               queue-based line model and an expected-word scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gene_line_sequencer;

    localparam int N_CYCLES = 20000;

    typedef struct {
        logic [199:0] line;
        int           len;
        bit           err;
    } word_t;

    logic         clk;
    logic         rst_n;
    logic [7:0]   in_char;
    logic         in_valid;
    logic         in_ready;
    logic         flush;
    logic [199:0] out_line;
    logic [6:0]   out_len;
    logic         out_err;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  line_count;

    int n_tests;
    int n_fail;

    // Reference model
    logic [7:0]  m_chars[$];
    bit          m_err;
    int          m_phase;     // 0 collecting, 1 packing, 2 offering word
    word_t       m_words[$];
    logic [15:0] m_count;
    bit          m_last_taken;
    int          m_emitted;

    gene_line_sequencer #(
        .LINE_CHARS (100),
        .CNT_W      (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_char    (in_char),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_line   (out_line),
        .out_len    (out_len),
        .out_err    (out_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .line_count (line_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [199:0] got, input logic [199:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] code_of(input logic [7:0] ch);
        if (ch == 8'h43) return 2'd1;
        if (ch == 8'h47) return 2'd2;
        if (ch == 8'h54) return 2'd3;
        return 2'd0;
    endfunction

    function automatic bit is_acgt(input logic [7:0] ch);
        return (ch == 8'h41) || (ch == 8'h43) || (ch == 8'h47) || (ch == 8'h54);
    endfunction

    task automatic model_reset();
        m_chars.delete();
        m_words.delete();
        m_err   = 1'b0;
        m_phase = 0;
        m_count = '0;
    endtask

    task automatic model_close();
        word_t w;
        w.line = '0;
        foreach (m_chars[i]) begin
            w.line = w.line | (200'(code_of(m_chars[i])) << (2 * (99 - i)));
        end
        w.len = m_chars.size();
        w.err = m_err;
        m_words.push_back(w);
        m_chars.delete();
        m_err   = 1'b0;
        m_phase = 1;
    endtask

    // Applies the inputs present at a rising edge to the model.
    task automatic model_step();
        bit lf_taken;
        lf_taken     = 1'b0;
        m_last_taken = 1'b0;
        case (m_phase)
            0: begin
                if (in_valid) begin
                    m_last_taken = 1'b1;
                    if (in_char == 8'h0A) begin
                        lf_taken = 1'b1;
                    end else if (in_char != 8'h0D) begin
                        m_chars.push_back(is_acgt(in_char) ? in_char : 8'h41);
                        if (!is_acgt(in_char)) m_err = 1'b1;
                    end
                end
                if (m_chars.size() > 0 && (m_chars.size() == 100 || lf_taken || flush))
                    model_close();
            end
            1: m_phase = 2;
            default: begin
                if (out_ready) begin
                    void'(m_words.pop_front());
                    m_count++;
                    m_emitted++;
                    m_phase = 0;
                end
            end
        endcase
    endtask

    task automatic check_outputs();
        check_val("in_ready", 200'(in_ready), 200'(m_phase == 0));
        check_val("out_valid", 200'(out_valid), 200'(m_phase == 2));
        check_val("line_count", 200'(line_count), 200'(m_count));
        if (m_phase == 2 && m_words.size() > 0) begin
            check_val("out_line", out_line, m_words[0].line);
            check_val("out_len", 200'(out_len), 200'(m_words[0].len));
            check_val("out_err", 200'(out_err), 200'(m_words[0].err));
        end
    endtask

    task automatic check_reset_values();
        check_val("rst_in_ready", 200'(in_ready), 200'(1));
        check_val("rst_out_valid", 200'(out_valid), 200'(0));
        check_val("rst_out_line", out_line, 200'(0));
        check_val("rst_out_len", 200'(out_len), 200'(0));
        check_val("rst_out_err", 200'(out_err), 200'(0));
        check_val("rst_line_count", 200'(line_count), 200'(0));
    endtask

    task automatic pick_char(input int mode, output logic [7:0] ch);
        int r;
        logic [7:0] acgt[4];
        acgt[0] = 8'h41; acgt[1] = 8'h43; acgt[2] = 8'h47; acgt[3] = 8'h54;
        r = $urandom_range(0, 99);
        if (mode == 1) r = (r < 97) ? 0 : 95;
        if (r < 80) begin
            ch = acgt[$urandom_range(0, 3)];
        end else if (r < 86) begin
            ch = 8'h0A;
        end else if (r < 90) begin
            ch = 8'h0D;
        end else begin
            ch = 8'(($urandom_range(0, 255)));
            while (is_acgt(ch) || ch == 8'h0A || ch == 8'h0D)
                ch = 8'(($urandom_range(0, 255)));
        end
    endtask

    initial begin
        int mode;
        logic [7:0] ch;
        n_tests      = 0;
        n_fail       = 0;
        m_emitted    = 0;
        m_last_taken = 1'b1;
        rst_n        = 1'b0;
        in_char      = 8'h41;
        in_valid     = 1'b0;
        flush        = 1'b0;
        out_ready    = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;

        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            // Here: at a falling edge, outputs settled since the last rising edge.
            check_outputs();
            if (cyc % 2500 == 1700) begin
                // Asynchronous reset mid-operation, asserted between edges.
                #2 rst_n = 1'b0;
                #1 check_reset_values();
                model_reset();
                in_valid     = 1'b0;
                flush        = 1'b0;
                m_last_taken = 1'b1;
                @(negedge clk);
                rst_n = 1'b1;
                continue;
            end
            mode = (cyc / 600) % 3;
            // Producer holds a pending character until it is accepted.
            if (!in_valid || m_last_taken) begin
                in_valid = ($urandom_range(0, 99) < 80);
                pick_char(mode, ch);
                in_char = ch;
            end
            flush     = (mode == 0) ? ($urandom_range(0, 99) < 3) : 1'b0;
            out_ready = (mode == 2) ? ($urandom_range(0, 99) < 10) : ($urandom_range(0, 99) < 60);
            @(posedge clk);
            model_step();
            @(negedge clk);
        end

        check_val("lines_emitted_nonzero", 200'(m_emitted > 20), 200'(1));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gene_line_sequencer.md
# gene_line_sequencer

Streaming front end for the combinational gene line compressor. It accepts ASCII nucleotide characters one byte per cycle and assembles them MSB-first into an 800-bit line buffer. A line closes after 100 characters, on a newline, or on a flush request. The block then drives the buffer through `gene_line_compress` and presents the registered 200-bit packed line on a valid/ready output port.

## Interface
- `LINE_CHARS`, 100: characters per line. Fixed by the compressor's 800/200-bit ports and not to be overridden.
- `CNT_W`, 16: width of the emitted-line counter.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_char`  in  8  ASCII character.
- `in_valid`  in  1  `in_char` is valid.
- `in_ready`  out  1  block accepts a character this cycle.
- `flush`  in  1  single-cycle request to close a partial line.
- `out_line`  out  200  packed line; base 0 is in [199:198].
- `out_len`  out  7  number of real bases in `out_line` (1..100).
- `out_err`  out  1  line contained at least one non-ACGT character.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  consumer takes the word.
- `line_count`  out  CNT_W  number of lines emitted; wraps modulo 2^CNT_W.

## Operation
- **States.** FILL, COMP, EMIT. Reset state is FILL.
- **FILL.**
  - `in_ready`=1.
  - Accepted byte = `in_valid && in_ready`.
  - 'A', 'C', 'G', 'T' (0x41, 0x43, 0x47, 0x54) are written to char slot `cnt`; slot 0 is buffer bits [799:792]. Then `cnt`++.
  - 0x0D is ignored and not counted.
  - Any other byte except 0x0A is stored as 'A', sets the sticky `err` flag, and counts as a base.
- **Line close, FILL -> COMP.** Taken when any of the following holds:
  - the accepted base makes `cnt`==100;
  - 0x0A is accepted while `cnt`>0;
  - `flush`=1 while `cnt`>0 (after counting any base accepted in the same cycle).
- **Cases that do not close a line.**
  - 0x0A with `cnt`==0 is consumed and dropped, so empty lines and a newline directly after a full line produce nothing.
  - `flush` with `cnt`==0 is ignored.
- **COMP** (1 cycle).
  - `in_ready`=0.
  - `out_line` <= compressor output, `out_len` <= `cnt`, `out_err` <= `err`.
  - Next state EMIT.
- **EMIT.**
  - `out_valid`=1 and `in_ready`=0.
  - `out_line`, `out_len` and `out_err` stay stable until `out_valid && out_ready`.
  - On that handshake: `line_count`++, buffer reset to all 'A' (0x41 in every slot), `cnt`=0, `err`=0, next state FILL.
- **Padding.** Unused slots of a short line remain 'A' and encode as 00.
- **`flush` outside FILL** is ignored and not remembered.

## Timing
- **Reset values.** `in_ready`=1 (state FILL), `out_valid`=0, `out_line`=0, `out_len`=0, `out_err`=0, `line_count`=0. Internally `cnt`=0, `err`=0 and the buffer holds all 'A'.
- **Latency.** If the closing character or `flush` is taken at edge N, the block is in COMP during cycle N..N+1. `out_valid` rises after edge N+1.
- **Throughput.** At best one line per LINE_CHARS+2 cycles; the output handshake happens in the EMIT cycle itself.
- **Backpressure.** `out_ready` low holds EMIT indefinitely, with `in_ready`=0 for the whole time.
- **Input sampling.** `in_valid` is sampled only while `in_ready`=1. The producer must hold `in_char` until accepted.
- **Reset mid-operation.** Asynchronous. Any partial line or pending output is discarded immediately and all outputs return to their reset values.
- **Counter wrap.** `line_count` wraps from 2^CNT_W−1 to 0 silently.

## Structure
- Package `gene_pkg` holds:
  - `LINE_CHARS`=100, `LINE_BITS`=800, `PACK_BITS`=200;
  - ASCII constants for A, C, G, T, LF, CR;
  - 2-bit base codes A=00, C=01, G=10, T=11;
  - the state enum `{FILL, COMP, EMIT}`.
- One sub-module: `gene_line_compress`, the combinational 800->200 packer, instantiated once on the line buffer. No other hierarchy.

## Test plan
- **All A.** 100×'A', `out_ready`=1 -> one word: `out_line`=0, `out_len`=100, `out_err`=0, `line_count`=1, `out_valid` high exactly 2 cycles after the last accept.
- **All C then newline.** 100×'C' then 0x0A -> `out_line`=200'h5555…5 (50 hex '5'), `out_len`=100. The trailing LF yields no second word.
- **Short line.** "ACGT", 0x0D, 0x0A -> `out_line`[199:192]=8'h1B with the rest 0, `out_len`=4, `out_err`=0.
- **Invalid character.** "GNT" + `flush` -> `out_line`[199:194]=6'b100011, `out_len`=3, `out_err`=1.
- **Backpressure.** 100×'T' with `out_ready` low for 5 EMIT cycles -> `out_valid`=1, `in_ready`=0 and `out_line`=all-ones stable throughout. The word is taken on the cycle `out_ready` rises, and `in_ready` returns the next cycle.
- **Reset mid-line.** 50×'G', pulse `rst_n` low, then "A\n" -> `out_len`=1 and `out_line`=0. No residue of the Gs appears.
